// File: rtl/pipeline_sink_checker.sv
// Terminal valid/ready consumer: throttles ready_out with a programmable pattern and checks beats against an incrementing sequence.
// Latency: ready_out is registered; status updates on the edge of each transfer. Optional PIPELINE_SINK_PROTOCOL_CHECK_EN adds stalled-beat stability tracking.
// Backpressure: sink-generated ready only; never stalls on anything downstream.
module pipeline_sink_checker #(
    parameter int unsigned DW   = 8,
    parameter logic [7:0]  SEED = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [3:0]    duty_on,
    input  logic [3:0]    duty_off,
    input  logic [DW-1:0] exp_start,
    input  logic [15:0]   beat_target,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          ready_out,
    output logic [15:0]   beat_count,
    output logic [7:0]    err_count,
    output logic          err_flag,
    output logic [DW-1:0] first_err_data,
    output logic [DW-1:0] first_err_exp,
    output logic          done,
    output logic          proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic [15:0]   r_beat_count;
    logic [7:0]    r_err_count;
    logic          r_err_flag;
    logic [DW-1:0] r_first_err_data;
    logic [DW-1:0] r_first_err_exp;
    logic [DW-1:0] r_expected;
    logic          r_done;
    logic [1:0]    r_mode;
    logic [3:0]    r_duty_on;
    logic [3:0]    r_duty_off;
    logic [15:0]   r_beat_target;
    logic [7:0]    r_lfsr;
    logic [4:0]    r_duty_cnt;

    logic          w_xfer;
    logic          w_mismatch;
    logic          w_hit_target;
    logic          w_pattern;
    logic [7:0]    w_lfsr_nxt;
    logic [4:0]    w_duty_period;
    logic [4:0]    w_duty_cnt_inc;
    logic [4:0]    w_duty_cnt_nxt;
    logic [15:0]   w_beat_nxt;
    logic [DW-1:0] w_exp_nxt;

    assign w_xfer         = valid_in && r_ready && (r_state == S_RUN);
    assign w_mismatch     = (data_in != r_expected);
    assign w_beat_nxt     = r_beat_count + 16'd1;
    assign w_hit_target   = (r_beat_target != 16'd0) && (w_beat_nxt == r_beat_target);
    assign w_exp_nxt      = data_in + DW'(1);

    // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
    assign w_lfsr_nxt     = r_lfsr[0] ? ((r_lfsr >> 1) ^ 8'hB8) : (r_lfsr >> 1);

    // A zero-length period (both counts zero) pins the counter at 0 and ready low.
    assign w_duty_period  = {1'b0, r_duty_on} + {1'b0, r_duty_off};
    assign w_duty_cnt_inc = r_duty_cnt + 5'd1;
    assign w_duty_cnt_nxt = (w_duty_cnt_inc >= w_duty_period) ? 5'd0 : w_duty_cnt_inc;

    always_comb begin
        w_pattern = 1'b0;
        case (r_mode)
            2'b00:   w_pattern = 1'b1;
            2'b01:   w_pattern = 1'b0;
            2'b10:   w_pattern = r_lfsr[0];
            default: w_pattern = (r_duty_cnt < {1'b0, r_duty_on});
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_ready          <= 1'b0;
            r_beat_count     <= 16'd0;
            r_err_count      <= 8'd0;
            r_err_flag       <= 1'b0;
            r_first_err_data <= '0;
            r_first_err_exp  <= '0;
            r_expected       <= '0;
            r_done           <= 1'b0;
            r_mode           <= 2'b00;
            r_duty_on        <= 4'd0;
            r_duty_off       <= 4'd0;
            r_beat_target    <= 16'd0;
            r_lfsr           <= SEED;
            r_duty_cnt       <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (enable) begin
                        r_state          <= S_RUN;
                        r_done           <= 1'b0;
                        r_beat_count     <= 16'd0;
                        r_err_count      <= 8'd0;
                        r_err_flag       <= 1'b0;
                        r_first_err_data <= '0;
                        r_first_err_exp  <= '0;
                        r_expected       <= exp_start;
                        r_mode           <= mode;
                        r_duty_on        <= duty_on;
                        r_duty_off       <= duty_off;
                        r_beat_target    <= beat_target;
                        r_lfsr           <= SEED;
                        r_duty_cnt       <= 5'd0;
                    end
                end
                S_RUN: begin
                    // Expected value resyncs to the received data so one glitch costs one error.
                    if (w_xfer) begin
                        r_beat_count <= w_beat_nxt;
                        r_expected   <= w_exp_nxt;
                        if (w_mismatch) begin
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            if (!r_err_flag) begin
                                r_err_flag       <= 1'b1;
                                r_first_err_data <= data_in;
                                r_first_err_exp  <= r_expected;
                            end
                        end
                    end
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end else if (w_xfer && w_hit_target) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ready    <= w_pattern;
                        r_lfsr     <= w_lfsr_nxt;
                        r_duty_cnt <= w_duty_cnt_nxt;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPELINE_SINK_PROTOCOL_CHECK_EN
    logic          r_proto_err;
    logic          r_stall_pend;
    logic [DW-1:0] r_stall_dat;

    // A beat offered while ready is low must stay put, unchanged, until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err  <= 1'b0;
            r_stall_pend <= 1'b0;
            r_stall_dat  <= '0;
        end else if (r_state == S_IDLE && enable) begin
            r_proto_err  <= 1'b0;
            r_stall_pend <= 1'b0;
            r_stall_dat  <= '0;
        end else if (r_state == S_RUN) begin
            if (r_stall_pend && (!valid_in || data_in != r_stall_dat)) begin
                r_proto_err <= 1'b1;
            end
            r_stall_pend <= valid_in && !r_ready;
            r_stall_dat  <= data_in;
        end else begin
            r_stall_pend <= 1'b0;
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

    assign ready_out      = r_ready;
    assign beat_count     = r_beat_count;
    assign err_count      = r_err_count;
    assign err_flag       = r_err_flag;
    assign first_err_data = r_first_err_data;
    assign first_err_exp  = r_first_err_exp;
    assign done           = r_done;

endmodule
